// File: rtl/cacheline_adaptor_param.sv
// LLC <-> memory cacheline/burst converter: one LINE_WIDTH line <-> BEATS beats of BURST_WIDTH,
// tolerating gaps between beats and optionally aborting stalled bursts after TIMEOUT_CYCLES idle cycles.
//   state    | meaning
//   IDLE     | waiting for read_i/write_i; read wins when both are high
//   RD_BURST | collecting beats from memory into the line buffer
//   WR_BURST | presenting line slices to memory, one per resp_i
//   DONE     | one-cycle resp_o (err_o set if the burst timed out)
module cacheline_adaptor_param #(
  parameter int LINE_WIDTH     = 256,
  parameter int BURST_WIDTH    = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  output logic                   err_o,
  output logic                   busy_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS   = $clog2(LINE_WIDTH / 8);
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TLOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((64'd1 << OFS) - 64'd1);

  generate
    if (BEATS < 2 || (LINE_WIDTH % BURST_WIDTH) != 0) begin : g_bad_params
      $error("cacheline_adaptor_param: LINE_WIDTH must be a multiple of BURST_WIDTH with at least 2 beats");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [TW-1:0]           tmr;
  logic                    err_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   data_q;
  logic [LINE_WIDTH-1:0]   line_merged;
  logic                    in_burst;
  logic                    last_beat;
  logic                    timeout;

  assign in_burst  = (state == RD_BURST) || (state == WR_BURST);
  assign last_beat = resp_i && (cnt == CW'(BEATS - 1));
  // tmr is a down-counter reloaded on every beat; terminal count with no beat means a stall.
  assign timeout   = (TIMEOUT_CYCLES > 0) && in_burst && !resp_i && (tmr == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (read_i)       state_nxt = RD_BURST;
        else if (write_i) state_nxt = WR_BURST;
      end
      RD_BURST, WR_BURST: begin
        if (last_beat || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    line_merged = data_q;
    line_merged[cnt*BURST_WIDTH +: BURST_WIDTH] = burst_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      tmr    <= '0;
      err_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      line_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          err_q <= 1'b0;
          tmr   <= TW'(TLOAD);
          if (read_i || write_i) addr_q <= address_i & ~OFS_MASK;
          if (!read_i && write_i) data_q <= line_i;
        end
        RD_BURST, WR_BURST: begin
          if (resp_i) begin
            tmr <= TW'(TLOAD);
            if (state == RD_BURST) data_q[cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
            if (last_beat) begin
              cnt <= '0;
              // only a complete read ever reaches line_o; aborted reads leave it untouched
              if (state == RD_BURST) line_o <= line_merged;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (timeout) begin
            err_q <= 1'b1;
            cnt   <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    read_o    = (state == RD_BURST);
    write_o   = (state == WR_BURST);
    resp_o    = (state == DONE);
    err_o     = (state == DONE) && err_q;
    busy_o    = (state != IDLE);
    address_o = addr_q;
    burst_o   = data_q[cnt*BURST_WIDTH +: BURST_WIDTH];
  end

endmodule
